// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer for the 3-bit signed calculator ALU: collects operands,
// sign and operator, then captures the ALU result on "=". Macro CALC_CHAIN_EN enables result chaining.
module calc_entry_ctrl #(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_s,
    input  logic [4:0] alu_r,
    input  logic       alu_sf,
    input  logic       alu_zf,
    input  logic       alu_dzf,
    input  logic       alu_ef,
    input  logic       alu_of,
    output logic [4:0] res,
    output logic [4:0] res_flags,
    output logic       res_valid,
    output logic       err
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        EVAL    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        a_mag, b_mag;
    logic              a_neg, b_neg;
    logic              a_has, b_has;
    logic [CNT_W-1:0]  cnt;

    logic accept, is_digit, is_neg, is_op, is_eq, is_clr, to_fire;

    // Sign/magnitude to two's complement; "-0" folds to zero.
    function automatic logic [2:0] enc(input logic neg, input logic [1:0] mag);
        logic [2:0] m;
        m = {1'b0, mag};
        return (neg && mag != 2'd0) ? (~m + 3'd1) : m;
    endfunction

    always_comb begin
        accept   = key_valid && (state != EVAL);
        is_digit = (key_code[3:2] == 2'b00);
        is_neg   = (key_code == 4'h4);
        is_op    = (key_code[3:2] == 2'b10);
        is_eq    = (key_code == 4'hC);
        is_clr   = (key_code == 4'hF);
        to_fire  = (TIMEOUT != 0) && (state == SHOW) && !accept
                   && (cnt == CNT_W'(TIMEOUT - 1));
    end

`ifdef CALC_CHAIN_EN
    logic res_in_range;
    always_comb res_in_range = ($signed(res) >= -5'sd3) && ($signed(res) <= 5'sd3);
`endif

    // NOTE: every register here is updated with <= so all state moves together on the
    // clock edge; blocking assignments would let later statements see half-updated values.
    always_ff @(posedge clk) begin
        if (!rst_n || (accept && is_clr) || to_fire) begin
            state     <= ENTER_A;
            alu_a     <= 3'd0;
            alu_b     <= 3'd0;
            alu_s     <= 2'b00;
            res       <= 5'd0;
            res_flags <= 5'd0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            key_ready <= 1'b1;
            a_mag     <= 2'd0;
            b_mag     <= 2'd0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            a_has     <= 1'b0;
            b_has     <= 1'b0;
            cnt       <= '0;
        end else begin
            key_ready <= 1'b1;
            if ((TIMEOUT != 0) && (state == SHOW) && !accept)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            case (state)
                ENTER_A: if (accept) begin
                    if (is_digit) begin
                        a_mag <= key_code[1:0];
                        a_has <= 1'b1;
                        alu_a <= enc(a_neg, key_code[1:0]);
                    end else if (is_neg) begin
                        a_neg <= ~a_neg;
                        alu_a <= enc(~a_neg, a_mag);
                    end else if (is_op && a_has) begin
                        alu_s <= key_code[1:0];
                        b_mag <= 2'd0;
                        b_neg <= 1'b0;
                        b_has <= 1'b0;
                        alu_b <= 3'd0;
                        state <= ENTER_B;
                    end
                end

                ENTER_B: if (accept) begin
                    if (is_digit) begin
                        b_mag <= key_code[1:0];
                        b_has <= 1'b1;
                        alu_b <= enc(b_neg, key_code[1:0]);
                    end else if (is_neg) begin
                        b_neg <= ~b_neg;
                        alu_b <= enc(~b_neg, b_mag);
                    end else if (is_op) begin
                        alu_s <= key_code[1:0];
                    end else if (is_eq && b_has) begin
                        key_ready <= 1'b0;
                        state     <= EVAL;
                    end
                end

                // ALU inputs have been stable for a full cycle; sample its combinational result.
                EVAL: begin
                    res       <= alu_r;
                    res_flags <= {alu_sf, alu_zf, alu_dzf, alu_ef, alu_of};
                    err       <= alu_dzf | alu_ef | alu_of;
                    res_valid <= 1'b1;
                    state     <= SHOW;
                end

                SHOW: if (accept) begin
                    if (is_digit) begin
                        a_mag     <= key_code[1:0];
                        a_neg     <= 1'b0;
                        a_has     <= 1'b1;
                        alu_a     <= {1'b0, key_code[1:0]};
                        b_mag     <= 2'd0;
                        b_neg     <= 1'b0;
                        b_has     <= 1'b0;
                        alu_b     <= 3'd0;
                        res_valid <= 1'b0;
                        err       <= 1'b0;
                        state     <= ENTER_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_op) begin
                        if (!err && res_in_range) begin
                            a_neg     <= res[4];
                            a_mag     <= res[4] ? (~res[1:0] + 2'd1) : res[1:0];
                            a_has     <= 1'b1;
                            alu_a     <= res[2:0];
                            alu_s     <= key_code[1:0];
                            b_mag     <= 2'd0;
                            b_neg     <= 1'b0;
                            b_has     <= 1'b0;
                            alu_b     <= 3'd0;
                            res_valid <= 1'b0;
                            state     <= ENTER_B;
                        end else begin
                            err <= 1'b1;
                        end
                    end
`endif
                end

                default: state <= ENTER_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl with a behavioural 3-bit signed ALU stub.
module tb_calc_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic [2:0] alu_a, alu_b;
    logic [1:0] alu_s;
    logic [4:0] alu_r;
    logic       alu_sf, alu_zf, alu_dzf, alu_ef, alu_of;
    logic [4:0] res, res_flags;
    logic       res_valid, err;

    localparam logic [3:0] K_NEG = 4'h4, K_ADD = 4'h8, K_SUB = 4'h9, K_MUL = 4'hA,
                           K_REM = 4'hB, K_EQ = 4'hC, K_CLR = 4'hF;

    always #5 clk = ~clk;

    calc_entry_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_r(alu_r), .alu_sf(alu_sf), .alu_zf(alu_zf), .alu_dzf(alu_dzf),
        .alu_ef(alu_ef), .alu_of(alu_of), .res(res), .res_flags(res_flags),
        .res_valid(res_valid), .err(err)
    );

    // ALU stub: REM by zero yields 0 with DZF.
    int   ta, tb_v, tr;
    logic tdz;
    always_comb begin
        ta   = int'($signed(alu_a));
        tb_v = int'($signed(alu_b));
        tr   = 0;
        tdz  = 1'b0;
        case (alu_s)
            2'b00: tr = ta + tb_v;
            2'b01: tr = ta - tb_v;
            2'b10: tr = ta * tb_v;
            default: begin
                if (tb_v == 0) tdz = 1'b1;
                else           tr  = ta % tb_v;
            end
        endcase
        alu_r   = tr[4:0];
        alu_sf  = tr[4];
        alu_zf  = (tr[4:0] == 5'd0);
        alu_dzf = tdz;
        alu_ef  = 1'b0;
        alu_of  = 1'b0;
    end

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] f;
        logic       e;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [4:0] f, input logic e);
        exp_t x;
        x.r = r;
        x.f = f;
        x.e = e;
        sb_q.push_back(x);
    endtask

    // Monitor: each new result presented by the DUT is matched against the next expectation.
    logic prev_valid = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (res_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("res", res, mon_e.r);
                check("res_flags", res_flags, mon_e.f);
                check("err", err, mon_e.e);
            end
        end
        prev_valid = res_valid;
    end

    // Keys are presented at a falling edge and sampled at the following rising edge.
    task automatic press(input logic [3:0] c);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_s"}, alu_s, 0);
        check({tag, "_res"}, res, 0);
        check({tag, "_res_flags"}, res_flags, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_key_ready"}, key_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        rst_n = 1'b1;
        press(4'h1); press(K_ADD); press(4'h2);
        // Reset with a simultaneous key: reset wins.
        rst_n = 1'b0; key_code = 4'h3; key_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; key_valid = 1'b0;
        check_cleared("reset");
        press(4'h2);
        check("reset_then_digit_alu_a", alu_a, 3'b010);

        // 2 + (-3) = -1
        press(K_ADD); press(4'h3); press(K_NEG);
        check("add_alu_a", alu_a, 3'b010);
        check("add_alu_b", alu_b, 3'b101);
        check("add_alu_s", alu_s, 2'b00);
        push(5'b11111, 5'b10000, 1'b0);
        press(K_EQ);
        check("eval_key_ready", key_ready, 0);
        idle(1);
        check("add_res_valid", res_valid, 1);

        // 3 REM 0 -> divide by zero
        press(4'h3); press(K_REM); press(4'h0);
        push(5'b00000, 5'b01100, 1'b1);
        press(K_EQ);
        idle(1);
        check("dz_err", err, 1);
        press(4'h1);
        check("dz_digit_res_valid", res_valid, 0);
        check("dz_digit_err", err, 0);
        check("dz_digit_alu_a", alu_a, 3'b001);

        // 1 + 2 = 3, then an operator in SHOW
        press(K_ADD); press(4'h2);
        push(5'b00011, 5'b00000, 1'b0);
        press(K_EQ);
        idle(1);
        press(K_MUL);
`ifdef CALC_CHAIN_EN
        check("chain_alu_a", alu_a, 3'b011);
        check("chain_alu_s", alu_s, 2'b10);
        check("chain_res_valid", res_valid, 0);
        press(4'h2);
        check("chain_alu_b", alu_b, 3'b010);
        push(5'b00110, 5'b00000, 1'b0);
        press(K_EQ);
        idle(1);
        press(K_ADD);
        check("chain_range_err", err, 1);
        check("chain_range_valid", res_valid, 1);
        check("chain_range_res", res, 5'b00110);
        check("chain_range_alu_s", alu_s, 2'b10);
`else
        check("nochain_res_valid", res_valid, 1);
        check("nochain_res", res, 5'b00011);
        check("nochain_alu_s", alu_s, 2'b00);
        check("nochain_err", err, 0);
`endif

        // CLR in the middle of operand B
        press(4'h1); press(K_SUB); press(4'h2);
        check("preclr_alu_s", alu_s, 2'b01);
        check("preclr_alu_b", alu_b, 3'b010);
        press(K_CLR);
        check_cleared("clr");

        // Key during EVAL is dropped: 3 * 1 = 3
        press(4'h3); press(K_MUL); press(4'h1);
        push(5'b00011, 5'b00000, 1'b0);
        press(K_EQ);
        check("drop_key_ready_low", key_ready, 0);
        press(K_SUB);
        check("drop_alu_s", alu_s, 2'b10);
        check("drop_key_ready_high", key_ready, 1);
        check("drop_res_valid", res_valid, 1);

        // Timeout: an ignored key at idle cycle 7 restarts the count
        idle(6);
        press(K_NEG);
        check("to_restart_valid", res_valid, 1);
        idle(7);
        check("to_before_valid", res_valid, 1);
        idle(1);
        check("to_fired_valid", res_valid, 0);
        check("to_fired_res", res, 0);
        press(4'h3);
        check("to_enter_a_alu_a", alu_a, 3'b011);

        idle(2);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
